// File: rtl/restoring_division_pkg.sv
// Shared types and constants for the restoring divider controller.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state encoding, the datapath control-strobe bundle and sizing constants.
package restoring_division_pkg;

  localparam int DIV_W      = 4;      // operand / quotient width of the datapath
  localparam int ITERATIONS = DIV_W;  // one quotient bit per iteration
  localparam int CNT_W      = 5;      // width of the optional busy-cycle counter

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    SHIFT,
    SUB,
    TEST,
    RESTORE,
    COUNT,
    LOAD_RES,
    DONE,
    DZERO
  } state_t;

  // Every strobe that goes to restoring_division_datapath.
  typedef struct packed {
    logic select_A;
    logic select_Q;
    logic ld_A;
    logic ld_Q;
    logic shift_left_enable_a;
    logic shift_left_enable_q;
    logic select_add;
    logic select_mux_2;
    logic count_enable;
    logic ld_rem_quotient;
  } ctrl_t;

endpackage

// File: rtl/restoring_division_ctrl_decode.sv
// Purpose: combinational state -> datapath strobe / handshake decoder (Moore outputs).
// Latency: 0 cycles (pure combinational on the state register).
// Backpressure: none; ready is simply high in IDLE.
// Ports: state (in), ctrl strobe bundle, ready, busy, done, div_by_zero (out).
module restoring_division_ctrl_decode
  import restoring_division_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl,
  output logic   ready,
  output logic   busy,
  output logic   done,
  output logic   div_by_zero
);

  always_comb begin
    ctrl        = '0;
    ready       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      DZERO: begin
        // No datapath strobes: the divide is answered without touching A/Q.
        done        = 1'b1;
        div_by_zero = 1'b1;
      end
      INIT: begin
        // select_A=0 clears A, select_Q=0 loads the dividend into Q.
        ctrl.ld_A = 1'b1;
        ctrl.ld_Q = 1'b1;
      end
      SHIFT: begin
        ctrl.shift_left_enable_a = 1'b1;
      end
      SUB: begin
        // A <= shifted A - M while Q shifts in the new quotient bit.
        ctrl.select_mux_2        = 1'b1;
        ctrl.select_A            = 1'b1;
        ctrl.ld_A                = 1'b1;
        ctrl.shift_left_enable_q = 1'b1;
        ctrl.select_Q            = 1'b1;
        ctrl.ld_Q                = 1'b1;
      end
      TEST: begin
        // Only the branch on negative_flag happens here.
      end
      RESTORE: begin
        // select_add=0, select_mux_2=0 picks the adder: A <= A + M.
        ctrl.select_A = 1'b1;
        ctrl.ld_A     = 1'b1;
      end
      COUNT: begin
        ctrl.count_enable = 1'b1;
      end
      LOAD_RES: begin
        ctrl.ld_rem_quotient = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        // Unused encodings behave like IDLE; the FSM steers them back there.
        ready = 1'b1;
        busy  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/restoring_division_controller.sv
// Purpose: FSM sequencing restoring_division_datapath for one 4b/4b unsigned divide per start.
// Latency: done in cycle 19+R after accept (R = zero quotient bits); divide-by-zero done next cycle.
// Backpressure: start accepted only while ready (IDLE); start in any other state is dropped.
// Ports: clk, rst (sync, active-high), start, divisor, negative_flag, status in;
//        ready, busy, done, div_by_zero and the ten datapath strobes out.
// Optional: define DIV_CYCLE_COUNT_EN to add the cycles[CNT_W-1:0] output (busy cycles of last divide).
module restoring_division_controller
  import restoring_division_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] divisor,
  input  logic             negative_flag,
  input  logic             status,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             select_A,
  output logic             select_Q,
  output logic             ld_A,
  output logic             ld_Q,
  output logic             shift_left_enable_a,
  output logic             shift_left_enable_q,
  output logic             select_add,
  output logic             select_mux_2,
  output logic             count_enable,
  output logic             ld_rem_quotient
`ifdef DIV_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? DZERO : INIT;
        end
      end
      INIT:     state_nxt = SHIFT;
      SHIFT:    state_nxt = SUB;
      SUB:      state_nxt = TEST;
      TEST:     state_nxt = negative_flag ? RESTORE : COUNT;
      RESTORE:  state_nxt = COUNT;
      // status is the pre-increment count; the counter wraps to 0 on the
      // last iteration so the next divide starts from a clean count.
      COUNT:    state_nxt = status ? LOAD_RES : SHIFT;
      LOAD_RES: state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      DZERO:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  restoring_division_ctrl_decode u_decode (
    .state       (state),
    .ctrl        (ctrl),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  assign select_A            = ctrl.select_A;
  assign select_Q            = ctrl.select_Q;
  assign ld_A                = ctrl.ld_A;
  assign ld_Q                = ctrl.ld_Q;
  assign shift_left_enable_a = ctrl.shift_left_enable_a;
  assign shift_left_enable_q = ctrl.shift_left_enable_q;
  assign select_add          = ctrl.select_add;
  assign select_mux_2        = ctrl.select_mux_2;
  assign count_enable        = ctrl.count_enable;
  assign ld_rem_quotient     = ctrl.ld_rem_quotient;

`ifdef DIV_CYCLE_COUNT_EN
  // cyc_cnt holds 0 through IDLE so it is cleared on the accept edge, then
  // counts busy cycles. The terminal state's own cycle is added when loading.
  logic [CNT_W-1:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      cycles  <= '0;
    end else begin
      if (state == IDLE) begin
        cyc_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      if (state == DONE || state == DZERO) begin
        cycles <= cyc_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_restoring_division_controller.sv
// Bench for restoring_division_controller with a behavioural datapath alongside it.
module tb_restoring_division_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] divisor;
  logic [3:0] dividend;
  logic       negative_flag;
  logic       status;
  logic       ready, busy, done, div_by_zero;
  logic       select_A, select_Q, ld_A, ld_Q;
  logic       shift_left_enable_a, shift_left_enable_q;
  logic       select_add, select_mux_2, count_enable, ld_rem_quotient;
`ifdef DIV_CYCLE_COUNT_EN
  logic [restoring_division_pkg::CNT_W-1:0] cycles;
`endif

  always #5 clk = ~clk;

  restoring_division_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .divisor             (divisor),
    .negative_flag       (negative_flag),
    .status              (status),
    .ready               (ready),
    .busy                (busy),
    .done                (done),
    .div_by_zero         (div_by_zero),
    .select_A            (select_A),
    .select_Q            (select_Q),
    .ld_A                (ld_A),
    .ld_Q                (ld_Q),
    .shift_left_enable_a (shift_left_enable_a),
    .shift_left_enable_q (shift_left_enable_q),
    .select_add          (select_add),
    .select_mux_2        (select_mux_2),
    .count_enable        (count_enable),
    .ld_rem_quotient     (ld_rem_quotient)
`ifdef DIV_CYCLE_COUNT_EN
    ,
    .cycles              (cycles)
`endif
  );

  // Behavioural restoring-division datapath driven by the controller strobes.
  logic [4:0] a;
  logic [3:0] q, m, quo, rem;
  logic [1:0] cnt;
  logic [4:0] diff;

  assign diff          = a - {1'b0, m};
  assign negative_flag = a[4];
  assign status        = (cnt == 2'd3);

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      a   <= 5'd0;
      q   <= 4'd0;
      m   <= 4'd0;
      quo <= 4'd0;
      rem <= 4'd0;
    end else begin
      if (count_enable) cnt <= cnt + 2'd1;
      if (ld_A) begin
        if (!select_A)        a <= 5'd0;
        else if (select_mux_2) a <= diff;
        else                   a <= a + {1'b0, m};
      end else if (shift_left_enable_a) begin
        a <= {a[3:0], q[3]};
      end
      if (ld_Q) begin
        if (!select_Q) begin
          q <= dividend;
          m <= divisor;
        end else if (shift_left_enable_q) begin
          q <= {q[2:0], ~diff[4]};
        end
      end
      if (ld_rem_quotient) begin
        quo <= q;
        rem <= a[3:0];
      end
    end
  end

  logic [9:0] strobes;
  assign strobes = {select_A, select_Q, ld_A, ld_Q, shift_left_enable_a,
                    shift_left_enable_q, select_add, select_mux_2,
                    count_enable, ld_rem_quotient};

  int done_total = 0;
  always @(posedge clk) begin
    if (done === 1'b1) done_total <= done_total + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One divide: waits for ready, pulses start, follows the run to done.
  // poke re-asserts start mid-run to show it is ignored while busy.
  task automatic run_div(input logic [3:0] dd, input logic [3:0] dv, input bit poke,
                         output int lat, output int restores, output int dz,
                         output int dp_any, output int sel_add_seen);
    int  n;
    bit  seen;
    lat = 0; restores = 0; dz = 0; dp_any = 0; sel_add_seen = 0;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_wait_timeout", 0, 1);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      start = (poke && (c == 5 || c == 6));
      if (ld_A && select_A && !select_mux_2) restores++;
      if (ld_A || ld_Q || count_enable || ld_rem_quotient) dp_any = 1;
      if (select_add) sel_add_seen = 1;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        dz   = div_by_zero;
      end
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0] dd;
    logic [3:0] dv;
    int q;
    int r;
    int lat;
    int res;
    int dz;
  } vec_t;

  localparam int NV = 9;
  vec_t tv[NV];

  initial begin
    int lat, res, dz, dp_any, sa, d0, n_sub;

    tv[0] = '{4'd13, 4'd3,  4,  1, 22, 3, 0};
    tv[1] = '{4'd15, 4'd1,  15, 0, 19, 0, 0};
    tv[2] = '{4'd7,  4'd0,  0,  0, 1,  0, 1};
    tv[3] = '{4'd0,  4'd5,  0,  0, 23, 4, 0};
    tv[4] = '{4'd8,  4'd3,  2,  2, 22, 3, 0};
    tv[5] = '{4'd14, 4'd15, 0,  14, 23, 4, 0};
    tv[6] = '{4'd15, 4'd15, 1,  0, 22, 3, 0};
    tv[7] = '{4'd6,  4'd4,  1,  2, 22, 3, 0};
    tv[8] = '{4'd12, 4'd2,  6,  0, 21, 2, 0};

    rst = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", div_by_zero, 0);
    chk("reset_strobes", strobes, 0);
`ifdef DIV_CYCLE_COUNT_EN
    chk("reset_cycles", cycles, 0);
`endif

    // Reset during the second SUB aborts with no done.
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_sub = 0;
    for (int c = 0; c < 40; c++) begin
      if (shift_left_enable_q) n_sub++;
      if (n_sub == 2) break;
      @(negedge clk);
    end
    chk("rst_sub_reached", n_sub, 2);
    d0  = done_total;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sub_ready", ready, 1);
    chk("rst_sub_busy", busy, 0);
    chk("rst_sub_done", done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sub_no_done", done_total - d0, 0);
    chk("rst_sub_idle", ready, 1);

    for (int i = 0; i < NV; i++) begin
      d0 = done_total;
      run_div(tv[i].dd, tv[i].dv, 1'b0, lat, res, dz, dp_any, sa);
      chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("v%0d_restores", i), res, tv[i].res);
      chk($sformatf("v%0d_dz", i), dz, tv[i].dz);
      chk($sformatf("v%0d_select_add", i), sa, 0);
      if (tv[i].dz != 0) begin
        chk($sformatf("v%0d_dz_no_strobes", i), dp_any, 0);
      end else begin
        chk($sformatf("v%0d_quotient", i), quo, tv[i].q);
        chk($sformatf("v%0d_remainder", i), rem, tv[i].r);
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", i), ready, 1);
      chk($sformatf("v%0d_one_done", i), done_total - d0, 1);
`ifdef DIV_CYCLE_COUNT_EN
      chk($sformatf("v%0d_cycles", i), cycles, tv[i].lat);
`endif
    end

    // 0/5 with start poked while busy, then a start held through DONE.
    d0 = done_total;
    run_div(4'd0, 4'd5, 1'b1, lat, res, dz, dp_any, sa);
    chk("poke_latency", lat, 23);
    chk("poke_quotient", quo, 0);
    chk("poke_remainder", rem, 0);
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    @(negedge clk);
    chk("done_start_ignored_ready", ready, 1);
    chk("done_start_ignored_busy", busy, 0);
    run_div(4'd9, 4'd2, 1'b0, lat, res, dz, dp_any, sa);
    chk("b2b_latency", lat, 22);
    chk("b2b_quotient", quo, 4);
    chk("b2b_remainder", rem, 1);
    @(negedge clk);
    chk("b2b_done_count", done_total - d0, 2);
    chk("b2b_ready_after", ready, 1);

    // Exhaustive sweep against the bench's own integer division.
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        d0 = done_total;
        run_div(dd[3:0], dv[3:0], 1'b0, lat, res, dz, dp_any, sa);
        if (dv == 0) begin
          chk($sformatf("sw_%0d_%0d_dz", dd, dv), dz, 1);
        end else begin
          chk($sformatf("sw_%0d_%0d_q", dd, dv), quo, dd / dv);
          chk($sformatf("sw_%0d_%0d_r", dd, dv), rem, dd % dv);
        end
        @(negedge clk);
        chk($sformatf("sw_%0d_%0d_one_done", dd, dv), done_total - d0, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/restoring_division_controller.md
Name: restoring_division_controller

Overview:
- FSM that sequences restoring_division_datapath for one 4-bit / 4-bit unsigned divide per request.
- Accepts start/operand handshake upstream and drives every datapath control strobe.
- Reads back negative_flag and status from the datapath.
- Presents done / div_by_zero to the consumer; quotient and remainder are read from the datapath output registers.

Parameters:
- ITERATIONS, 4, quotient bits per divide; must equal datapath width. Status (count==ITERATIONS-1) marks last iteration.
- CNT_W, 5, width of optional cycle counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- divisor  input  4  sampled on accept for zero check; must be held stable until done
- negative_flag  input  1  datapath A[4]==1
- status  input  1  datapath count==3
- ready  output  1  high in IDLE only
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; results valid from this cycle until next accept
- div_by_zero  output  1  one-cycle pulse with done when divisor==0
- select_A, select_Q, ld_A, ld_Q, shift_left_enable_a, shift_left_enable_q, select_add, select_mux_2, count_enable, ld_rem_quotient  output  1 each  datapath controls

Behaviour:
- All outputs are Moore-decoded from the state register.
- Every control not listed for a state is 0.
- Reset:
  - state=IDLE; all controls 0; ready=1; busy=done=div_by_zero=0.
  - rst mid-operation aborts immediately, with no done. rst also clears the datapath counter, so no cleanup is needed.
- IDLE:
  - start & divisor!=0 -> INIT.
  - start & divisor==0 -> DZERO.
- DZERO: done=1, div_by_zero=1; no datapath strobes -> IDLE.
- INIT: ld_A=1, select_A=0 (A<=0); ld_Q=1, select_Q=0 (Q<=dividend) -> SHIFT.
- SHIFT: shift_left_enable_a=1 -> SUB.
- SUB:
  - select_mux_2=1, select_A=1, ld_A=1 (A <= shifted A - M).
  - shift_left_enable_q=1, select_Q=1, ld_Q=1.
  - -> TEST.
- TEST: negative_flag=1 -> RESTORE, else -> COUNT.
- RESTORE: select_add=0, select_mux_2=0, select_A=1, ld_A=1 (A <= A + M) -> COUNT.
- COUNT:
  - count_enable=1, always asserted. The counter wraps 3->0 on the last iteration, leaving it cleared for the next divide.
  - status=1 (sampled before increment) -> LOAD_RES, else -> SHIFT.
- LOAD_RES: ld_rem_quotient=1 -> DONE.
- DONE: done=1 -> IDLE. A start asserted in DONE is ignored; ready returns the next cycle.
- Latency:
  - Busy cycles before DONE = 1 (INIT) + 4*ITERATIONS + R + 1 (LOAD_RES) = 18+R, where R = number of restores = count of zero quotient bits.
  - done is high in cycle 19+R after accept.
- start while busy is ignored. Back-to-back divides are separated by at least one IDLE cycle.

Optional Feature:
- Macro: DIV_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycles [CNT_W-1:0]. An internal counter clears on accept and increments each busy cycle, DONE included.
  - cycles is loaded on DONE and held until the next DONE.
  - Reset value 0. DZERO loads 1.
- Undefined: no port, no counter logic. All other behaviour is identical.

Decomposition:
- Shared package restoring_division_pkg holds:
  - state enum: IDLE, INIT, SHIFT, SUB, TEST, RESTORE, COUNT, LOAD_RES, DONE, DZERO.
  - DIV_W=4, ITERATIONS, CNT_W.
- One natural sub-module: restoring_division_ctrl_decode, a combinational state -> control-strobe decoder. The FSM next-state logic stays in the top.
- A test-only top, restoring_division_top, instantiates the controller plus the datapath.

Test Plan:
- rst held 3 cycles, then released -> ready=1, busy=0, all strobes 0. rst asserted mid-SUB -> IDLE next cycle, no done.
- 13/3 -> quotient=4, remainder=1, three RESTORE visits, done 22 cycles after accept; cycles=22 with DIV_CYCLE_COUNT_EN.
- 15/1 -> quotient=15, remainder=0, no RESTORE, done 19 cycles after accept.
- 7/0 -> DZERO; done and div_by_zero both high in cycle after accept; ld_A, ld_Q, count_enable never asserted.
- 0/5 -> quotient=0, remainder=0, four restores, done 23 cycles after accept. start pulsed during busy is ignored; the back-to-back 9/2 divide gives quotient=4, remainder=1, confirming the counter wrapped to 0.
- Random sweep of all 256 dividend/divisor pairs -> quotient and remainder match reference division; exactly one done per accepted start.
